// File: rtl/rf_sequencer_if.sv
// Host/controller-facing signal bundle for the RF turn-on/turn-off sequencer.
// The master side issues requests and limits; the slave side is the sequencer.
interface rf_sequencer_if #(
    parameter int unsigned aw = 18,
    parameter int unsigned dw = 16
) ();
    logic          start;
    logic          stop;
    logic          clear_trip;
    logic          master_cic_tick;
    logic [aw-2:0] amp_target;
    logic [aw-2:0] ramp_step;
    logic [dw-1:0] dwell;
    logic [11:0]   cmp_event;
    logic [11:0]   trip_mask;
    logic [6:0]    sat_count;
    logic [6:0]    sat_limit;

    logic          ctlr_ph_reset;
    logic [aw-1:0] amp_sp;
    logic          rf_on;
    logic          loop_close;
    logic          trip;
    logic [12:0]   trip_cause;
    logic [2:0]    seq_state;

    modport master (
        output start, stop, clear_trip, master_cic_tick,
        output amp_target, ramp_step, dwell,
        output cmp_event, trip_mask, sat_count, sat_limit,
        input  ctlr_ph_reset, amp_sp, rf_on, loop_close, trip, trip_cause, seq_state
    );

    modport slave (
        input  start, stop, clear_trip, master_cic_tick,
        input  amp_target, ramp_step, dwell,
        input  cmp_event, trip_mask, sat_count, sat_limit,
        output ctlr_ph_reset, amp_sp, rf_on, loop_close, trip, trip_cause, seq_state
    );
endinterface

// File: rtl/rf_sequencer.sv
// RF feedback-loop sequencer: phase reset, tick-aligned amplitude ramp, dwell,
// loop close, ramp-down and a latched safe-state trip.
module rf_sequencer #(
    parameter int unsigned aw = 18,
    parameter int unsigned dw = 16
) (
    input logic           clk,
    input logic           rst_n,
    rf_sequencer_if.slave bus
);
    localparam int unsigned AMP_W = aw - 1;
    localparam int unsigned CMP_W = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PHASE   = 3'd1,
        RAMP_UP = 3'd2,
        SETTLE  = 3'd3,
        RUN     = 3'd4,
        RAMP_DN = 3'd5,
        TRIP    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic [AMP_W-1:0]   target_q, target_d;
    logic [dw-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic               rf_on_q, rf_on_d;
    logic               loop_q, loop_d;
    logic               trip_q, trip_d;
    logic               ph_q, ph_d;
    logic [CMP_W:0]     cause_q, cause_d;

    logic [CMP_W-1:0]   cmp_hit;
    logic               sat_hit;
    logic               trip_hit;
    logic [AMP_W:0]     up_sum;
    logic [AMP_W-1:0]   up_val;
    logic [AMP_W-1:0]   dn_val;

    assign cmp_hit  = bus.cmp_event & bus.trip_mask;
    assign sat_hit  = (bus.sat_limit != 7'd0) && (bus.sat_count >= bus.sat_limit);
    assign trip_hit = (|cmp_hit) || sat_hit;

    // Saturating ramp arithmetic; one extra bit on the sum so it cannot wrap.
    assign up_sum = {1'b0, amp_q} + {1'b0, bus.ramp_step};
    assign up_val = ((bus.ramp_step == '0) || (up_sum >= {1'b0, target_q}))
                    ? target_q : up_sum[AMP_W-1:0];
    assign dn_val = ((bus.ramp_step == '0) || (amp_q <= bus.ramp_step))
                    ? '0 : amp_q - bus.ramp_step;

    always_comb begin
        state_d     = state_q;
        amp_d       = amp_q;
        target_d    = target_q;
        dwell_cnt_d = dwell_cnt_q;
        rf_on_d     = rf_on_q;
        loop_d      = loop_q;
        trip_d      = trip_q;
        cause_d     = cause_q;
        ph_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = PHASE;
                    ph_d        = 1'b1;
                    target_d    = bus.amp_target;
                    dwell_cnt_d = bus.dwell;
                end
            end
            PHASE, RAMP_UP, SETTLE, RUN, RAMP_DN: begin
                if (trip_hit) begin
                    state_d = TRIP;
                    amp_d   = '0;
                    rf_on_d = 1'b0;
                    loop_d  = 1'b0;
                    trip_d  = 1'b1;
                    cause_d = {sat_hit, cmp_hit};
                end else if (bus.stop && (state_q != RAMP_DN)) begin
                    state_d = RAMP_DN;
                    loop_d  = 1'b0;
                end else if (bus.master_cic_tick) begin
                    case (state_q)
                        PHASE: begin
                            state_d = RAMP_UP;
                            rf_on_d = 1'b1;
                        end
                        RAMP_UP: begin
                            amp_d = up_val;
                            if (up_val == target_q) state_d = SETTLE;
                        end
                        // Counter reaching zero on this tick closes the loop.
                        SETTLE: begin
                            if (dwell_cnt_q <= dw'(1)) begin
                                state_d     = RUN;
                                loop_d      = 1'b1;
                                dwell_cnt_d = '0;
                            end else begin
                                dwell_cnt_d = dwell_cnt_q - dw'(1);
                            end
                        end
                        RAMP_DN: begin
                            amp_d = dn_val;
                            if (dn_val == '0) begin
                                state_d = IDLE;
                                rf_on_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            TRIP: begin
                if (bus.clear_trip) begin
                    if (trip_hit) begin
                        cause_d = {sat_hit, cmp_hit};
                    end else begin
                        state_d = IDLE;
                        trip_d  = 1'b0;
                        cause_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                amp_d   = '0;
                rf_on_d = 1'b0;
                loop_d  = 1'b0;
                trip_d  = 1'b0;
                cause_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            amp_q       <= '0;
            target_q    <= '0;
            dwell_cnt_q <= '0;
            rf_on_q     <= 1'b0;
            loop_q      <= 1'b0;
            trip_q      <= 1'b0;
            cause_q     <= '0;
            ph_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            amp_q       <= amp_d;
            target_q    <= target_d;
            dwell_cnt_q <= dwell_cnt_d;
            rf_on_q     <= rf_on_d;
            loop_q      <= loop_d;
            trip_q      <= trip_d;
            cause_q     <= cause_d;
            ph_q        <= ph_d;
        end
    end

    assign bus.ctlr_ph_reset = ph_q;
    assign bus.amp_sp        = {1'b0, amp_q};
    assign bus.rf_on         = rf_on_q;
    assign bus.loop_close    = loop_q;
    assign bus.trip          = trip_q;
    assign bus.trip_cause    = cause_q;
    assign bus.seq_state     = state_q;
endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench for rf_sequencer: directed scenarios plus randomized
// traffic, all checked every cycle against a behavioural reference model.
module tb_rf_sequencer;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

    localparam int S_IDLE = 0, S_PHASE = 1, S_UP = 2, S_SETTLE = 3,
                   S_RUN = 4, S_DN = 5, S_TRIP = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_sequencer_if #(.aw(AW), .dw(DW)) bus ();
    rf_sequencer #(.aw(AW), .dw(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state, in the spec's own terms.
    int m_state, m_amp, m_target, m_dwell_left, m_cause;
    int m_rf, m_loop, m_trip, m_ph;

    int amp_log[$];
    int last_amp = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_amp = 0; m_target = 0; m_dwell_left = 0; m_cause = 0;
        m_rf = 0; m_loop = 0; m_trip = 0; m_ph = 0;
    endtask

    task automatic model_step();
        int hit, sat, cause, stp;
        hit   = int'(bus.cmp_event & bus.trip_mask);
        sat   = (bus.sat_limit != 7'd0 && bus.sat_count >= bus.sat_limit) ? 1 : 0;
        cause = hit + sat * 4096;
        stp   = int'(bus.ramp_step);
        m_ph  = 0;
        if (m_state == S_IDLE) begin
            if (bus.start) begin
                m_state = S_PHASE; m_ph = 1;
                m_target = int'(bus.amp_target); m_dwell_left = int'(bus.dwell);
            end
        end else if (m_state == S_TRIP) begin
            if (bus.clear_trip) begin
                if (cause != 0) m_cause = cause;
                else begin m_state = S_IDLE; m_trip = 0; m_cause = 0; end
            end
        end else if (cause != 0) begin
            m_state = S_TRIP; m_amp = 0; m_rf = 0; m_loop = 0; m_trip = 1; m_cause = cause;
        end else if (bus.stop && m_state != S_DN) begin
            m_state = S_DN; m_loop = 0;
        end else if (bus.master_cic_tick) begin
            if (m_state == S_PHASE) begin
                m_state = S_UP; m_rf = 1;
            end else if (m_state == S_UP) begin
                if (stp == 0 || m_amp + stp > m_target) m_amp = m_target;
                else m_amp = m_amp + stp;
                if (m_amp == m_target) m_state = S_SETTLE;
            end else if (m_state == S_SETTLE) begin
                m_dwell_left = (m_dwell_left > 0) ? m_dwell_left - 1 : 0;
                if (m_dwell_left == 0) begin m_state = S_RUN; m_loop = 1; end
            end else if (m_state == S_DN) begin
                m_amp = (stp == 0 || stp > m_amp) ? 0 : m_amp - stp;
                if (m_amp == 0) begin m_state = S_IDLE; m_rf = 0; end
            end
        end
    endtask

    task automatic check_all();
        check_eq("seq_state",  32'(bus.seq_state),     32'(m_state));
        check_eq("amp_sp",     32'(bus.amp_sp),        32'(m_amp));
        check_eq("rf_on",      32'(bus.rf_on),         32'(m_rf));
        check_eq("loop_close", 32'(bus.loop_close),    32'(m_loop));
        check_eq("trip",       32'(bus.trip),          32'(m_trip));
        check_eq("trip_cause", 32'(bus.trip_cause),    32'(m_cause));
        check_eq("ph_reset",   32'(bus.ctlr_ph_reset), 32'(m_ph));
    endtask

    // One clock: model follows the sampled inputs, outputs checked 1 unit later.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        cyc++;
        check_all();
        if (32'(bus.amp_sp) != 32'(last_amp)) begin
            last_amp = int'(bus.amp_sp);
            amp_log.push_back(last_amp);
        end
    endtask

    task automatic run_until(input int want_state, input int want_amp, input int period,
                             input int budget, input string tag);
        int n = 0;
        while (!(m_state == want_state && (want_amp < 0 || m_amp == want_amp)) && n < budget) begin
            bus.master_cic_tick = ((cyc % period) == period - 1);
            step();
            bus.master_cic_tick = 1'b0;
            n++;
        end
        if (n >= budget) begin
            check_eq({"timeout_state_", tag}, 32'(m_state), 32'(want_state));
            if (want_amp >= 0) check_eq({"timeout_amp_", tag}, 32'(m_amp), 32'(want_amp));
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_trip = 1'b1; step(); bus.clear_trip = 1'b0;
    endtask

    task automatic set_profile(input int tgt, input int stp, input int dw_ticks);
        bus.amp_target = 17'(tgt);
        bus.ramp_step  = 17'(stp);
        bus.dwell      = 16'(dw_ticks);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_up[4] = '{300, 600, 900, 1000};
        int exp_dn[4] = '{700, 400, 100, 0};

        rst_n = 1'b0;
        bus.start = 0; bus.stop = 0; bus.clear_trip = 0; bus.master_cic_tick = 0;
        bus.amp_target = 0; bus.ramp_step = 0; bus.dwell = 0;
        bus.cmp_event = 0; bus.trip_mask = 0; bus.sat_count = 0; bus.sat_limit = 0;
        model_reset();

        // Reset state
        repeat (3) step();
        check_eq("reset_state", 32'(bus.seq_state), 32'(0));
        check_eq("reset_amp",   32'(bus.amp_sp),    32'(0));
        rst_n = 1'b1;
        repeat (3) step();

        // Ramp-up, dwell, run; host edits after start must not matter
        set_profile(1000, 300, 2);
        pulse_start();
        check_eq("ph_reset_pulse", 32'(bus.ctlr_ph_reset), 32'(1));
        step();
        check_eq("ph_reset_single", 32'(bus.ctlr_ph_reset), 32'(0));
        bus.amp_target = 17'(50);
        bus.dwell      = 16'(9);
        amp_log.delete();
        run_until(S_RUN, -1, 33, 600, "ramp_up");
        check_eq("ramp_up_len", 32'(amp_log.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("ramp_up_amp%0d", i), 32'(amp_log[i]), 32'(exp_up[i]));
        check_eq("run_loop_close", 32'(bus.loop_close), 32'(1));
        repeat (40) step();

        // Stop from RUN
        amp_log.delete();
        pulse_stop();
        check_eq("stop_loop_open", 32'(bus.loop_close), 32'(0));
        check_eq("stop_state", 32'(bus.seq_state), 32'(5));
        run_until(S_IDLE, -1, 33, 600, "ramp_dn");
        check_eq("ramp_dn_len", 32'(amp_log.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("ramp_dn_amp%0d", i), 32'(amp_log[i]), 32'(exp_dn[i]));
        check_eq("ramp_dn_rf_off", 32'(bus.rf_on), 32'(0));

        // Comparator trip during RAMP_UP
        set_profile(1000, 300, 2);
        pulse_start();
        run_until(S_UP, 600, 33, 600, "to_600");
        bus.cmp_event = 12'h004; bus.trip_mask = 12'h004;
        step();
        bus.cmp_event = 12'h000;
        check_eq("trip_state", 32'(bus.seq_state), 32'(6));
        check_eq("trip_amp", 32'(bus.amp_sp), 32'(0));
        check_eq("trip_cause_cmp", 32'(bus.trip_cause), 32'h0004);
        pulse_start();
        check_eq("trip_ignores_start", 32'(bus.seq_state), 32'(6));
        pulse_clear();
        check_eq("clear_to_idle", 32'(bus.seq_state), 32'(0));
        bus.trip_mask = 12'h000;

        // Saturation trip, disabled when limit is 0
        set_profile(1000, 300, 2);
        pulse_start();
        run_until(S_RUN, -1, 33, 600, "sat_run");
        bus.sat_limit = 7'd0; bus.sat_count = 7'd127;
        repeat (20) step();
        check_eq("sat_disabled", 32'(bus.seq_state), 32'(4));
        bus.sat_limit = 7'd5; bus.sat_count = 7'd5;
        step();
        check_eq("sat_trip_cause", 32'(bus.trip_cause), 32'h1000);
        bus.sat_limit = 7'd0; bus.sat_count = 7'd0;
        pulse_clear();

        // ramp_step 0 jumps to target, and to zero on the way down
        set_profile(5000, 0, 1);
        pulse_start();
        run_until(S_UP, -1, 33, 100, "jump_phase");
        amp_log.delete();
        run_until(S_SETTLE, -1, 33, 100, "jump_up");
        check_eq("jump_len", 32'(amp_log.size()), 32'(1));
        check_eq("jump_amp", 32'(amp_log[0]), 32'(5000));
        run_until(S_RUN, -1, 33, 100, "jump_run");
        pulse_stop();
        run_until(S_IDLE, -1, 33, 100, "jump_dn");

        // Zero target passes RAMP_UP in one tick
        set_profile(0, 300, 0);
        pulse_start();
        run_until(S_UP, -1, 33, 100, "zero_phase");
        run_until(S_SETTLE, -1, 33, 40, "zero_up");
        run_until(S_RUN, -1, 33, 40, "zero_settle");
        pulse_stop();
        run_until(S_IDLE, -1, 33, 40, "zero_dn");

        // stop and trip together; clear while condition persists re-latches
        set_profile(800, 400, 1);
        pulse_start();
        run_until(S_RUN, -1, 33, 600, "both_run");
        bus.stop = 1'b1; bus.cmp_event = 12'h001; bus.trip_mask = 12'h001;
        step();
        bus.stop = 1'b0;
        check_eq("stop_trip_prio", 32'(bus.seq_state), 32'(6));
        bus.cmp_event = 12'h003; bus.trip_mask = 12'h003;
        pulse_clear();
        check_eq("relatch_state", 32'(bus.seq_state), 32'(6));
        check_eq("relatch_cause", 32'(bus.trip_cause), 32'h0003);
        bus.cmp_event = 12'h000; bus.trip_mask = 12'h000;
        pulse_clear();

        // Asynchronous reset mid-ramp
        set_profile(1000, 300, 2);
        pulse_start();
        run_until(S_UP, 600, 33, 600, "rst_600");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("async_rst_amp", 32'(bus.amp_sp), 32'(0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bus.master_cic_tick = ((cyc % 33) == 32);
            step();
            bus.master_cic_tick = 1'b0;
        end
        check_eq("post_rst_idle", 32'(bus.seq_state), 32'(0));

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.start           = ($urandom_range(0, 99) < 4);
            bus.stop            = ($urandom_range(0, 99) < 2);
            bus.clear_trip      = ($urandom_range(0, 99) < 6);
            bus.master_cic_tick = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: bus.amp_target = 17'h1FFFF;
                1: bus.amp_target = 17'(0);
                default: bus.amp_target = 17'($urandom_range(0, 3000));
            endcase
            bus.dwell = 16'($urandom_range(0, 4));
            if ((i % 64) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.ramp_step = 17'(0);
                    1: bus.ramp_step = 17'h1FFFF;
                    default: bus.ramp_step = 17'($urandom_range(1, 700));
                endcase
                bus.sat_limit = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(4, 10));
            end
            bus.trip_mask = 12'($urandom);
            bus.cmp_event = ($urandom_range(0, 199) == 0) ? 12'($urandom) : 12'h000;
            bus.sat_count = ($urandom_range(0, 299) == 0) ? 7'd127 : 7'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
